gx4000_asic_ram_arbiter: RTL and testbench

- Shares the single-port 16 KB ASIC RAM (`asic_ram_*` port of the ACID block) between three requesters:
  - sprite/video fetch
  - DMA sound engine
  - Z80 CPU page-in window at &4000-&7FFF
- Grants one access per cycle, fixed priority, optional CPU starvation guard.
- Gates CPU access on Plus mode and ASIC unlock status.
- Sits between the requesters and the ACID RAM port.

---
 rtl/gx4000_asic_ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gx4000_asic_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_asic_ram_arbiter.sv
// Fixed-priority (SPR > DMA > CPU) one-grant-per-cycle arbiter for the ACID 16 KB ASIC RAM port.
// Optional CPU starvation guard, enabled by defining GX4000_ARB_STARVE_GUARD_EN.
module gx4000_asic_ram_arbiter #(
    parameter  int unsigned CPU_MAX_WAIT = 4,
    localparam int unsigned AW           = 14,
    localparam int unsigned DW           = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          plus_mode,
    input  logic          asic_valid,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    output logic          spr_ack,
    output logic [DW-1:0] spr_rdata,
    output logic          spr_rvalid,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_q,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SPR  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    localparam logic [DW-1:0] GATED_RDATA = DW'(8'hFF);

    if (CPU_MAX_WAIT < 1 || CPU_MAX_WAIT > 15) begin : g_bad_cpu_max_wait
        $error("CPU_MAX_WAIT must lie in 1..15");
    end

    owner_e owner_q;
    owner_e grant_c;
    logic   spr_elig_c;
    logic   dma_elig_c;
    logic   cpu_elig_c;
    logic   cpu_open_c;
    logic   cpu_first_c;

    // Outstanding read: issued at the grant edge, ram_q captured at the following edge.
    logic   ret_valid;
    owner_e ret_owner;
    logic   ret_gated;

    assign owner = owner_q;

    // The previous winner is masked so its falling req cannot win a second time.
    always_comb begin
        spr_elig_c = spr_req && plus_mode && (owner_q != OWN_SPR);
        dma_elig_c = dma_req && plus_mode && (owner_q != OWN_DMA);
        cpu_elig_c = cpu_req && (owner_q != OWN_CPU);
        cpu_open_c = plus_mode && asic_valid;
        grant_c    = OWN_NONE;
        if (cpu_elig_c && cpu_first_c) begin
            grant_c = OWN_CPU;
        end else if (spr_elig_c) begin
            grant_c = OWN_SPR;
        end else if (dma_elig_c) begin
            grant_c = OWN_DMA;
        end else if (cpu_elig_c) begin
            grant_c = OWN_CPU;
        end
    end

`ifdef GX4000_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);

    logic [3:0] cpu_wait;

    // Counts eligible-but-losing cycles; at saturation the CPU takes the next decision.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_wait <= '0;
        end else if (!cpu_req || grant_c == OWN_CPU) begin
            cpu_wait <= '0;
        end else if (cpu_elig_c && cpu_wait != WAIT_MAX) begin
            cpu_wait <= cpu_wait + 4'd1;
        end
    end

    assign cpu_first_c = (cpu_wait == WAIT_MAX);
`else
    assign cpu_first_c = 1'b0;
`endif

    // Grant stage: owner, acks, RAM strobes and the return-register entry.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner_q   <= OWN_NONE;
            spr_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_din   <= '0;
            ret_valid <= 1'b0;
            ret_owner <= OWN_NONE;
            ret_gated <= 1'b0;
        end else begin
            owner_q   <= grant_c;
            spr_ack   <= (grant_c == OWN_SPR);
            dma_ack   <= (grant_c == OWN_DMA);
            cpu_ack   <= (grant_c == OWN_CPU);
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ret_valid <= 1'b0;
            ret_gated <= 1'b0;
            ret_owner <= grant_c;
            unique case (grant_c)
                OWN_SPR: begin
                    ram_addr  <= spr_addr;
                    ram_rd    <= 1'b1;
                    ret_valid <= 1'b1;
                end
                OWN_DMA: begin
                    ram_addr  <= dma_addr;
                    ram_rd    <= 1'b1;
                    ret_valid <= 1'b1;
                end
                OWN_CPU: begin
                    ram_addr  <= cpu_addr;
                    ram_din   <= cpu_wdata;
                    ram_wr    <= cpu_we && cpu_open_c;
                    ram_rd    <= !cpu_we && cpu_open_c;
                    ret_valid <= !cpu_we;
                    ret_gated <= !cpu_open_c;
                end
                default: ;
            endcase
        end
    end

    // Return stage: route ram_q (or &FF for a gated CPU read) to the recorded owner.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            spr_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            spr_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            spr_rvalid <= ret_valid && (ret_owner == OWN_SPR);
            dma_rvalid <= ret_valid && (ret_owner == OWN_DMA);
            cpu_rvalid <= ret_valid && (ret_owner == OWN_CPU);
            if (ret_valid) begin
                unique case (ret_owner)
                    OWN_SPR: spr_rdata <= ram_q;
                    OWN_DMA: dma_rdata <= ram_q;
                    OWN_CPU: cpu_rdata <= ret_gated ? GATED_RDATA : ram_q;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gx4000_asic_ram_arbiter.sv
// Bench for gx4000_asic_ram_arbiter: RAM model, read-return scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_gx4000_asic_ram_arbiter;

    localparam int unsigned CPU_MAX_WAIT = 4;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
    } ret_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        plus_mode, asic_valid;
    logic        spr_req, dma_req, cpu_req, cpu_we;
    logic [13:0] spr_addr, dma_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        spr_ack, dma_ack, cpu_ack;
    logic        spr_rvalid, dma_rvalid, cpu_rvalid;
    logic [7:0]  spr_rdata, dma_rdata, cpu_rdata;
    logic [13:0] ram_addr;
    logic        ram_rd, ram_wr;
    logic [7:0]  ram_din, ram_q;
    logic [1:0]  owner;

    logic [7:0]  mem [0:16383];
    ret_t        exp_q[$];
    logic        sb_on = 1'b1;
    int          n_total = 0;
    int          n_bad = 0;
    int          n_spr_ack = 0, n_dma_ack = 0, n_cpu_ack = 0, n_dma_rv = 0;

    always #5 clk_sys = ~clk_sys;

    gx4000_asic_ram_arbiter #(.CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .asic_valid(asic_valid),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_rdata(spr_rdata),
        .spr_rvalid(spr_rvalid),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_din(ram_din),
        .ram_q(ram_q), .owner(owner)
    );

    function automatic logic [7:0] ram_init(input int a);
        if (a == 16) return 8'h5A;
        return 8'((a * 37 + 11) ^ (a >> 6));
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({owner, ram_addr, ram_rd, ram_wr, ram_din, spr_ack, dma_ack, cpu_ack,
                    spr_rvalid, dma_rvalid, cpu_rvalid, spr_rdata, dma_rdata, cpu_rdata});
    endfunction

    // RAM model: data for the strobed address is presented while ram_rd is high.
    assign ram_q = mem[ram_addr];

    always @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) mem[i] <= ram_init(i);
        end else if (ram_wr) begin
            mem[ram_addr] <= ram_din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input logic [1:0] who, input logic [7:0] data);
        ret_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("rv_owner", 64'(who), 64'(e.who));
            chk("rv_data", 64'(data), 64'(e.data));
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Monitor: ack/rvalid counters and scoreboard pops, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (spr_ack === 1'b1) n_spr_ack++;
        if (dma_ack === 1'b1) n_dma_ack++;
        if (cpu_ack === 1'b1) n_cpu_ack++;
        if (dma_rvalid === 1'b1) n_dma_rv++;
        if (sb_on) begin
            if (spr_rvalid === 1'b1) sb_check(2'd1, spr_rdata);
            if (dma_rvalid === 1'b1) sb_check(2'd2, dma_rdata);
            if (cpu_rvalid === 1'b1) sb_check(2'd3, cpu_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b_spr, b_dma, b_cpu, b_rv, k, first_c, last_c, others;
        logic       seen;
        logic [1:0] order [3];

        reset = 1'b1; plus_mode = 1'b1; asic_valid = 1'b1;
        spr_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        spr_addr = '0; dma_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        chk("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", all_outs(), 64'd0);

        // Single sprite read: strobe/ack at N+1, data at N+2.
        spr_req = 1'b1; spr_addr = 14'h0010;
        exp_q.push_back('{who: 2'd1, data: 8'h5A});
        tick();
        chk("spr_ack", 64'(spr_ack), 64'd1);
        chk("spr_ram_rd", 64'(ram_rd), 64'd1);
        chk("spr_ram_addr", 64'(ram_addr), 64'h0010);
        chk("spr_owner_n1", 64'(owner), 64'd1);
        spr_req = 1'b0;
        tick();
        chk("spr_rvalid", 64'(spr_rvalid), 64'd1);
        chk("spr_rdata", 64'(spr_rdata), 64'h5A);
        chk("spr_owner_n2", 64'(owner), 64'd0);
        chk("spr_ack_n2", 64'(spr_ack), 64'd0);
        tick();

        // All three request together.
        b_spr = n_spr_ack; b_dma = n_dma_ack; b_cpu = n_cpu_ack;
        spr_req = 1'b1; spr_addr = 14'h0200;
        dma_req = 1'b1; dma_addr = 14'h0300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        exp_q.push_back('{who: 2'd1, data: ram_init(14'h0200)});
        exp_q.push_back('{who: 2'd2, data: ram_init(14'h0300)});
        exp_q.push_back('{who: 2'd3, data: ram_init(14'h0123)});
        k = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < 3; i++) order[i] = 2'd0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (owner != 2'd0 && k < 3) begin
                order[k] = owner;
                if (k == 0) first_c = c;
                last_c = c;
                k++;
            end
            if (spr_ack) spr_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
        end
        chk("prio_1st", 64'(order[0]), 64'd1);
        chk("prio_2nd", 64'(order[1]), 64'd2);
        chk("prio_3rd", 64'(order[2]), 64'd3);
        chk("prio_back_to_back", 64'(last_c - first_c), 64'd2);
        chk("prio_spr_acks", 64'(n_spr_ack - b_spr), 64'd1);
        chk("prio_dma_acks", 64'(n_dma_ack - b_dma), 64'd1);
        chk("prio_cpu_acks", 64'(n_cpu_ack - b_cpu), 64'd1);

        // CPU gated by a locked ASIC.
        asic_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'hAA;
        tick();
        chk("gw_ack", 64'(cpu_ack), 64'd1);
        chk("gw_ram_wr", 64'(ram_wr), 64'd0);
        cpu_req = 1'b0;
        tick();
        chk("gw_dropped", 64'(mem[14'h3FFF]), 64'(ram_init(14'h3FFF)));
        cpu_we = 1'b0; cpu_req = 1'b1;
        exp_q.push_back('{who: 2'd3, data: 8'hFF});
        tick();
        chk("gr_ack", 64'(cpu_ack), 64'd1);
        chk("gr_ram_rd", 64'(ram_rd), 64'd0);
        cpu_req = 1'b0;
        tick();
        chk("gr_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("gr_rdata", 64'(cpu_rdata), 64'hFF);
        asic_valid = 1'b1;
        cpu_we = 1'b1; cpu_req = 1'b1;
        tick();
        chk("uw_ram_wr", 64'(ram_wr), 64'd1);
        chk("uw_ram_addr", 64'(ram_addr), 64'h3FFF);
        chk("uw_ram_din", 64'(ram_din), 64'hAA);
        cpu_req = 1'b0;
        tick();
        chk("uw_mem", 64'(mem[14'h3FFF]), 64'hAA);
        cpu_we = 1'b0; cpu_req = 1'b1;
        exp_q.push_back('{who: 2'd3, data: 8'hAA});
        tick();
        chk("ur_ram_rd", 64'(ram_rd), 64'd1);
        cpu_req = 1'b0;
        tick();
        chk("ur_rdata", 64'(cpu_rdata), 64'hAA);
        tick();

        // plus_mode=0: video/DMA locked out, CPU gated.
        plus_mode = 1'b0;
        b_spr = n_spr_ack; b_dma = n_dma_ack;
        spr_req = 1'b1; dma_req = 1'b1;
        repeat (10) tick();
        chk("np_spr_acks", 64'(n_spr_ack - b_spr), 64'd0);
        chk("np_dma_acks", 64'(n_dma_ack - b_dma), 64'd0);
        cpu_we = 1'b0; cpu_addr = 14'h0040; cpu_req = 1'b1;
        exp_q.push_back('{who: 2'd3, data: 8'hFF});
        tick();
        chk("np_cpu_ack", 64'(cpu_ack), 64'd1);
        chk("np_ram_rd", 64'(ram_rd), 64'd0);
        cpu_req = 1'b0; spr_req = 1'b0; dma_req = 1'b0;
        tick();
        chk("np_cpu_rdata", 64'(cpu_rdata), 64'hFF);
        plus_mode = 1'b1;
        tick();

        // Starvation: SPR and DMA request continuously alongside the CPU.
        sb_on = 1'b0;
        spr_req = 1'b1; spr_addr = 14'h0100;
        dma_req = 1'b1; dma_addr = 14'h0101;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0555;
        seen = 1'b0; others = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            tick();
            if (cpu_ack) seen = 1'b1;
            else if (spr_ack || dma_ack) others++;
        end
        spr_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
`ifdef GX4000_ARB_STARVE_GUARD_EN
        chk("starve_cpu_acked", 64'(seen), 64'd1);
        chk("starve_wait", 64'(others), 64'(CPU_MAX_WAIT));
`else
        chk("starve_no_cpu_ack", 64'(seen), 64'd0);
        chk("starve_port_busy", 64'(others), 64'd50);
`endif
        repeat (4) tick();
        exp_q.delete();
        sb_on = 1'b1;

        // Reset one cycle into a DMA read: the read must never return.
        b_rv = n_dma_rv;
        dma_req = 1'b1; dma_addr = 14'h0777;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            if (dma_ack) seen = 1'b1;
        end
        chk("rst_dma_acked", 64'(seen), 64'd1);
        reset = 1'b1; dma_req = 1'b0;
        tick();
        chk("rst_outs", all_outs(), 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_no_rvalid", 64'(n_dma_rv - b_rv), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
